ifu_fetch: RTL

- Owns the architectural PC register and the instruction-fetch handshake with instruction memory; sits directly downstream of the next-PC select logic.
- Each cycle, drives the current PC and an advance-enable to the next-PC logic, and takes the selected next PC back.
- Issues one fetch at a time, buffers the returned instruction, and presents it to decode/execute with a valid/ready handshake.
- Loads the next PC only when the held instruction is consumed.

---
 rtl/ifu_fetch_pkg.sv | 19 +
 rtl/ifu_inst_buf.sv | 32 +++
 rtl/ifu_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC and FSM state encodings for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int unsigned CPU_WIDTH  = 64;
    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = 64;
    localparam int unsigned STATE_W    = 3;

    localparam logic [CPU_WIDTH-1:0] RESET_PC = 64'h8000_0000;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_REQ   = 3'd0;
    localparam state_t S_WAIT  = 3'd1;
    localparam state_t S_HOLD  = 3'd2;
    localparam state_t S_HALT  = 3'd3;
    localparam state_t S_FAULT = 3'd4;

endpackage

// File: rtl/ifu_inst_buf.sv
// Single-entry holding register for a fetched instruction and its PC.
//   clk, rst_n          : clock, async active-low reset
//   load                : capture load_inst/load_pc
//   clear               : return to reset contents (load has lower priority)
//   inst, inst_pc       : held instruction word and its PC
module ifu_inst_buf
    import ifu_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic [CPU_WIDTH-1:0]  load_pc,
    output logic [INST_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0]  inst_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst    <= '0;
            inst_pc <= RESET_PC;
        end else if (clear) begin
            inst    <= '0;
            inst_pc <= RESET_PC;
        end else if (load) begin
            inst    <= load_inst;
            inst_pc <= load_pc;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the architectural PC, issues one imem fetch at
// a time, holds the returned word for decode, and advances the PC on consume.
//   curr_pc / pc_ena / next_pc          : exchange with the next-PC select logic
//   halt                                : stop issuing new fetches
//   imem_req_* / imem_rsp_*             : instruction memory handshake
//   inst_valid / inst_ready / inst / inst_pc : held instruction to decode
//   fetch_fault                         : sticky access/misalignment fault
//   retire_cnt                          : number of consumed instructions
module ifu_fetch
    import ifu_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [CPU_WIDTH-1:0]  curr_pc,
    output logic                  pc_ena,
    input  logic [CPU_WIDTH-1:0]  next_pc,
    input  logic                  halt,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [CPU_WIDTH-1:0]  imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0]  inst_pc,
    output logic                  fetch_fault,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    state_t               state;
    state_t               state_nxt;
    logic [CPU_WIDTH-1:0] pc;
    logic                 consume;
    logic                 rsp_ok;

    // Responses only count while a fetch is outstanding; stale ones are dropped.
    assign rsp_ok  = (state == S_WAIT) && imem_rsp_valid && !imem_rsp_err;
    assign consume = (state == S_HOLD) && inst_ready;

    assign curr_pc       = pc;
    assign imem_req_addr = pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (halt) begin
                    state_nxt = S_HALT;
                end else if (imem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // halt is deliberately not sampled until the response lands.
                if (imem_rsp_valid) begin
                    state_nxt = imem_rsp_err ? S_FAULT : S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    if (next_pc[1:0] != 2'b00) begin
                        state_nxt = S_FAULT;
                    end else if (halt) begin
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end
            end
            S_HALT: begin
                if (!halt) begin
                    state_nxt = S_REQ;
                end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
    end

    // Output decode from state
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        pc_ena         = 1'b0;
        fetch_fault    = 1'b0;
        case (state)
            S_REQ:   imem_req_valid = !halt;
            S_HOLD: begin
                inst_valid = 1'b1;
                pc_ena     = inst_ready;
            end
            S_FAULT: fetch_fault = 1'b1;
            default: ;
        endcase
    end

    // PC and retire counter advance together on consume; a misaligned next_pc
    // is still loaded so the faulting target is visible on curr_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            retire_cnt <= '0;
        end else if (consume) begin
            pc         <= next_pc;
            retire_cnt <= retire_cnt + CNT_WIDTH'(1);
        end
    end

    // No in-band flush source exists yet; reset is the only clear.
    ifu_inst_buf u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (rsp_ok),
        .clear     (1'b0),
        .load_inst (imem_rsp_data),
        .load_pc   (pc),
        .inst      (inst),
        .inst_pc   (inst_pc)
    );

endmodule
